// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-port arbiter in front of a single-ported data RAM. One transaction is in
// flight at a time and walks IDLE -> ACCESS -> RESP:
//   IDLE   : a requester is granted (req_ready) and its request is latched.
//   ACCESS : the RAM is addressed; aligned stores pulse one strobe, aligned
//            loads capture and extend mem_rd into the response register.
//   RESP   : the granted port sees a one-cycle rsp_valid with rsp_err and
//            rsp_rdata.
//
// Configuration macro: DATA_MEM_ARBITER_RR_EN
//   defined   -> round-robin between the two ports on a tie
//   undefined -> fixed priority, port 0 always wins a tie
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[1:0]    per-port request valid
//   req_ready[1:0]    per-port grant (combinational, only in IDLE)
//   req_we[1:0]       1 = store, 0 = load
//   req_size[3:0]     2 bits per port: 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned[1:0] load zero-extend select
//   req_addr          per-port byte address, port i in slice i
//   req_wdata         per-port right-aligned store data, port i in slice i
//   rsp_valid[1:0]    per-port one-cycle response strobe
//   rsp_err           misalignment / illegal-size flag, valid with rsp_valid
//   rsp_rdata         extended load data, 0 for stores and errors
//   mem_a, mem_wd     RAM byte address and write data
//   mem_sb/sh/sw      RAM byte / half / word store strobes
//   mem_rd            RAM combinational read data, byte at mem_a in [7:0]
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [3:0]                  req_size,
    input  logic [1:0]                  req_unsigned,
    input  logic [2*ADDRESS_LENGTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [ADDRESS_LENGTH-1:0]   mem_a,
    output logic [DATA_WIDTH-1:0]       mem_wd,
    output logic                        mem_sb,
    output logic                        mem_sh,
    output logic                        mem_sw,
    input  logic [DATA_WIDTH-1:0]       mem_rd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                      state_r;
    logic                        port_r;
    logic                        we_r;
    logic [1:0]                  size_r;
    logic                        uns_r;
    logic [ADDRESS_LENGTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]       wdata_r;
    logic                        err_r;
    logic [DATA_WIDTH-1:0]       rdata_r;
`ifdef DATA_MEM_ARBITER_RR_EN
    logic                        last_grant_r;
`endif

    logic                        grant_s;
    logic                        sel_we_s;
    logic [1:0]                  sel_size_s;
    logic                        sel_uns_s;
    logic [ADDRESS_LENGTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]       sel_wdata_s;
    logic                        store_go_s;

    // Size 11 is never legal; half needs an even address, word a 4-byte one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Narrow loads come from the low lanes of mem_rd and are sign/zero extended.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0] size,
                                                          input logic uns,
                                                          input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] res;
        case (size)
            2'b00:   res = uns ? {{(DATA_WIDTH-8){1'b0}}, rd[7:0]}
                               : {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
            2'b01:   res = uns ? {{(DATA_WIDTH-16){1'b0}}, rd[15:0]}
                               : {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Arbitration: choose which valid port wins; only meaningful in IDLE.
    always_comb begin
        grant_s = 1'b0;
`ifdef DATA_MEM_ARBITER_RR_EN
        if (req_valid == 2'b11) begin
            grant_s = ~last_grant_r;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
`else
        if (req_valid[0]) begin
            grant_s = 1'b0;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
`endif
    end

    // Steer the granted port's request fields toward the latch registers.
    always_comb begin
        sel_we_s    = req_we[grant_s];
        sel_uns_s   = req_unsigned[grant_s];
        sel_size_s  = grant_s ? req_size[3:2] : req_size[1:0];
        sel_addr_s  = grant_s ? req_addr[2*ADDRESS_LENGTH-1:ADDRESS_LENGTH]
                              : req_addr[ADDRESS_LENGTH-1:0];
        sel_wdata_s = grant_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];
    end

    // Transaction FSM: latch on grant, capture load data in ACCESS, respond in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            port_r       <= 1'b0;
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            err_r        <= 1'b0;
            rdata_r      <= '0;
`ifdef DATA_MEM_ARBITER_RR_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        state_r      <= ST_ACCESS;
                        port_r       <= grant_s;
                        we_r         <= sel_we_s;
                        size_r       <= sel_size_s;
                        uns_r        <= sel_uns_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        err_r        <= misaligned(sel_size_s, sel_addr_s[1:0]);
`ifdef DATA_MEM_ARBITER_RR_EN
                        last_grant_r <= grant_s;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_RESP;
                    if (!we_r && !err_r) begin
                        rdata_r <= extend_load(size_r, uns_r, mem_rd);
                    end else begin
                        rdata_r <= '0;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state; rst gates the paths so they
    // drop immediately rather than at the next edge.
    always_comb begin
        store_go_s = (state_r == ST_ACCESS) && we_r && !err_r && !rst;
        mem_sb     = store_go_s && (size_r == 2'b00);
        mem_sh     = store_go_s && (size_r == 2'b01);
        mem_sw     = store_go_s && (size_r == 2'b10);
        if ((state_r != ST_IDLE) && !rst) begin
            mem_a  = addr_r;
            mem_wd = wdata_r;
        end else begin
            mem_a  = '0;
            mem_wd = '0;
        end
        if ((state_r == ST_IDLE) && !rst && (req_valid != 2'b00)) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        if ((state_r == ST_RESP) && !rst) begin
            rsp_valid = port_r ? 2'b10 : 2'b01;
            rsp_err   = err_r;
        end else begin
            rsp_valid = 2'b00;
            rsp_err   = 1'b0;
        end
        rsp_rdata = rdata_r;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
    localparam int AL = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we, req_unsigned, rsp_valid;
    logic [3:0]      req_size;
    logic [2*AL-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic            rsp_err, mem_sb, mem_sh, mem_sw;
    logic [DW-1:0]   rsp_rdata, mem_wd, mem_rd;
    logic [AL-1:0]   mem_a;

    data_mem_arbiter #(.ADDRESS_LENGTH(AL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_sb(mem_sb), .mem_sh(mem_sh), .mem_sw(mem_sw), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // 64-byte RAM, addresses alias on their low 6 bits.
    logic [7:0] ram [64];
    logic       poke_en = 1'b0;
    logic [5:0] poke_idx = 6'd0;
    logic [7:0] poke_val = 8'd0;

    always_comb begin
        mem_rd = {ram[mem_a[5:0] + 6'd3], ram[mem_a[5:0] + 6'd2],
                  ram[mem_a[5:0] + 6'd1], ram[mem_a[5:0]]};
    end

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        if (mem_sb) ram[mem_a[5:0]] <= mem_wd[7:0];
        if (mem_sh) begin
            ram[mem_a[5:0]]         <= mem_wd[7:0];
            ram[mem_a[5:0] + 6'd1]  <= mem_wd[15:8];
        end
        if (mem_sw) begin
            ram[mem_a[5:0]]         <= mem_wd[7:0];
            ram[mem_a[5:0] + 6'd1]  <= mem_wd[15:8];
            ram[mem_a[5:0] + 6'd2]  <= mem_wd[23:16];
            ram[mem_a[5:0] + 6'd3]  <= mem_wd[31:24];
        end
    end

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t       pend [2];
    logic [1:0] pend_v;
    logic [7:0] mram [64];
    logic       model_last;
    int         check_cnt = 0;
    int         err_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t gen_req();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.uns   = 1'($urandom_range(0, 1));
        r.addr  = 32'h1000 + 32'($urandom_range(0, 60));
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic logic is_err(input req_t r);
        if (r.size == 2'b11) return 1'b1;
        if (r.size == 2'b01) return (r.addr % 2) != 0;
        if (r.size == 2'b10) return (r.addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input req_t r);
        return (r.size == 2'b00) ? 1 : (r.size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input req_t r);
        int unsigned v = 0;
        int a = int'(r.addr % 64);
        int n = nbytes(r);
        for (int k = 0; k < n; k++) v = v + (int'(mram[(a + k) % 64]) << (8 * k));
        if (!r.uns && n == 1 && v >= 128)   v = v + 32'hFFFFFF00;
        if (!r.uns && n == 2 && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    function automatic void model_store(input req_t r);
        int a = int'(r.addr % 64);
        for (int k = 0; k < nbytes(r); k++) mram[(a + k) % 64] = 8'((r.wdata >> (8 * k)) & 32'hFF);
    endfunction

    function automatic int pick(input logic [1:0] v);
`ifdef DATA_MEM_ARBITER_RR_EN
        if (v == 2'b11) return model_last ? 0 : 1;
`else
        if (v == 2'b11) return 0;
`endif
        return v[0] ? 0 : 1;
    endfunction

    task automatic drive_ports();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]          = pend_v[i];
            req_we[i]             = pend[i].we;
            req_size[2*i +: 2]    = pend[i].size;
            req_unsigned[i]       = pend[i].uns;
            req_addr[AL*i +: AL]  = pend[i].addr;
            req_wdata[DW*i +: DW] = pend[i].wdata;
        end
    endtask

    task automatic inject(input logic [1:0] m);
        for (int i = 0; i < 2; i++) begin
            if (m[i] && !pend_v[i]) begin
                pend[i]   = gen_req();
                pend_v[i] = 1'b1;
            end
        end
        drive_ports();
    endtask

    task automatic poke(input int idx, input logic [7:0] val);
        poke_en = 1'b1; poke_idx = 6'(idx); poke_val = val;
        @(posedge clk); #1;
        poke_en = 1'b0;
        mram[idx] = val;
    endtask

    // One arbitration slot: an idle cycle, or a full accepted transaction.
    task automatic run_txn(input logic [1:0] inj_acc, input logic [1:0] inj_rsp,
                           output logic [1:0] obs_rdy, output logic [31:0] obs_data,
                           output logic obs_err);
        req_t t;
        int g;
        logic e;
        logic [31:0] exp_d;
        logic [2:0] exp_stb;
        obs_data = 32'd0; obs_err = 1'b0;
        drive_ports();
        @(negedge clk);
        obs_rdy = req_ready;
        check_val("idle_stb", {mem_sb, mem_sh, mem_sw}, 3'b000);
        check_val("idle_rsp", rsp_valid, 2'b00);
        check_val("idle_mem_a", mem_a, 32'd0);
        if (pend_v == 2'b00) begin
            check_val("idle_rdy", req_ready, 2'b00);
            @(posedge clk); #1;
            return;
        end
        g = pick(pend_v);
        check_val("grant", req_ready, (g == 0) ? 2'b01 : 2'b10);
        t = pend[g];
        pend_v[g] = 1'b0;
`ifdef DATA_MEM_ARBITER_RR_EN
        model_last = (g == 1);
`endif
        e = is_err(t);
        exp_d = (t.we || e) ? 32'd0 : model_load(t);
        @(posedge clk); #1;
        inject(inj_acc);
        @(negedge clk);
        check_val("acc_rdy", req_ready, 2'b00);
        check_val("acc_mem_a", mem_a, t.addr);
        check_val("acc_mem_wd", mem_wd, t.wdata);
        exp_stb = (t.we && !e) ? (3'b100 >> t.size) : 3'b000;
        check_val("acc_stb", {mem_sb, mem_sh, mem_sw}, exp_stb);
        check_val("acc_rsp", rsp_valid, 2'b00);
        @(posedge clk); #1;
        if (t.we && !e) model_store(t);
        inject(inj_rsp);
        @(negedge clk);
        check_val("rsp_rdy", req_ready, 2'b00);
        check_val("rsp_valid", rsp_valid, (g == 0) ? 2'b01 : 2'b10);
        check_val("rsp_err", rsp_err, e);
        check_val("rsp_rdata", rsp_rdata, exp_d);
        check_val("rsp_stb", {mem_sb, mem_sh, mem_sw}, 3'b000);
        obs_data = rsp_rdata;
        obs_err  = rsp_err;
        @(posedge clk); #1;
        drive_ports();
    endtask

    task automatic drain();
        logic [1:0] r; logic [31:0] d; logic e;
        for (int k = 0; k < 4 && pend_v != 2'b00; k++) run_txn(2'b00, 2'b00, r, d, e);
        check_val("drained", pend_v, 2'b00);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic        e;
        int          bad;

        rst = 1'b1;
        pend[0] = '0; pend[1] = '0; pend_v = 2'b00;
        model_last = 1'b1;
        drive_ports();
        for (int i = 0; i < 64; i++) begin
            ram[i]  = 8'($urandom);
            mram[i] = ram[i];
        end
        req_valid = 2'b11;
        #1;
        check_val("rst_ready", req_ready, 2'b00);
        check_val("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
        check_val("rst_stb", {mem_sb, mem_sh, mem_sw}, 3'b000);
        check_val("rst_mem_a", mem_a, 32'd0);
        check_val("rst_mem_wd", mem_wd, 32'd0);
        check_val("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_ports();
        @(posedge clk); #1;

        // Both ports valid continuously.
        pend[0] = mk(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0);
        pend[1] = mk(1'b0, 2'b10, 1'b0, 32'h1004, 32'd0);
        pend_v = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2'b00, r, d, e);
`ifdef DATA_MEM_ARBITER_RR_EN
            check_val("tie_seq", r, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            check_val("tie_seq", r, 2'b01);
`endif
        end
        drain();

        // Store word then load it back.
        pend[0] = mk(1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF); pend_v = 2'b01;
        run_txn(2'b00, 2'b00, r, d, e);
        pend[0] = mk(1'b0, 2'b10, 1'b0, 32'h1004, 32'd0); pend_v = 2'b01;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("sw_lw_data", d, 32'hDEADBEEF);
        check_val("sw_lw_err", e, 1'b0);

        // Signed and unsigned byte load of 0x80 on port 1.
        poke(16, 8'h80);
        pend[1] = mk(1'b0, 2'b00, 1'b0, 32'h1010, 32'd0); pend_v = 2'b10;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("lb_signed", d, 32'hFFFFFF80);
        pend[1] = mk(1'b0, 2'b00, 1'b1, 32'h1010, 32'd0); pend_v = 2'b10;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("lb_unsigned", d, 32'h00000080);

        // Misaligned stores.
        pend[0] = mk(1'b1, 2'b01, 1'b0, 32'h1001, 32'h1234_5678); pend_v = 2'b01;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("sh_mis_err", e, 1'b1);
        pend[0] = mk(1'b1, 2'b10, 1'b0, 32'h1002, 32'h9ABC_DEF0); pend_v = 2'b01;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("sw_mis_err", e, 1'b1);

        // Port 1 arrives during port 0's response slot.
        pend[0] = mk(1'b0, 2'b10, 1'b0, 32'h1008, 32'd0); pend_v = 2'b01;
        run_txn(2'b00, 2'b10, r, d, e);
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("late_grant", r, 2'b10);

        // Reset in the middle of a byte store.
        poke(0, 8'h3C);
        pend[0] = mk(1'b1, 2'b00, 1'b0, 32'h1000, 32'h000000A5); pend_v = 2'b01;
        drive_ports();
        @(negedge clk);
        check_val("rst_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        pend_v = 2'b00;
        drive_ports();
        check_val("rst_sb_pre", mem_sb, 1'b1);
        rst = 1'b1;
        #1;
        check_val("rst_sb_drop", {mem_sb, mem_sh, mem_sw}, 3'b000);
        check_val("rst_mid_mem_a", mem_a, 32'd0);
        @(posedge clk); #1;
        check_val("rst_ram", ram[0], 8'h3C);
        check_val("rst_no_rsp", rsp_valid, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_no_rsp_after", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;
        pend[0] = mk(1'b0, 2'b00, 1'b1, 32'h1000, 32'd0); pend_v = 2'b01;
        run_txn(2'b00, 2'b00, r, d, e);
        check_val("rst_idle_lb", d, 32'h0000003C);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 250; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = gen_req();
                    pend_v[i] = 1'b1;
                end
            end
            run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r, d, e);
        end
        drain();

        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== mram[i]) bad++;
        check_val("ram_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDRESS_LENGTH, default 32: width of request addresses and the RAM address bus.
REQ-002 Parameter DATA_WIDTH, default 32: width of write data, read data and response data.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  per-port request valid; bit i belongs to port i (i = 0, 1).
REQ-006 req_ready  output  2  per-port request accepted this cycle.
REQ-007 req_we  input  2  per-port request type: 1 = store, 0 = load.
REQ-008 req_size  input  4  per-port size, 2 bits per port at [2i+1:2i]: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  2  per-port load zero-extend select; 0 = sign-extend.
REQ-010 req_addr  input  2*ADDRESS_LENGTH  per-port byte address; port i occupies slice i.
REQ-011 req_wdata  input  2*DATA_WIDTH  per-port store data, right-aligned; port i occupies slice i.
REQ-012 rsp_valid  output  2  per-port one-cycle response strobe.
REQ-013 rsp_err  output  1  response carries a misalignment or illegal-size error; valid with rsp_valid.
REQ-014 rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 mem_a  output  ADDRESS_LENGTH  RAM byte address.
REQ-016 mem_wd  output  DATA_WIDTH  RAM write data.
REQ-017 mem_sb / mem_sh / mem_sw  output  1 each  RAM byte, half and word store strobes.
REQ-018 mem_rd  input  DATA_WIDTH  RAM combinational read data; the byte at mem_a is mem_rd[7:0].

Function
REQ-019 Behaviour is governed by an FSM with states IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any req_valid bit is set.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-020 In IDLE:
- req_ready is asserted combinationally for the granted port only.
- The granted port's we, size, unsigned, addr and wdata are latched on the same edge.
REQ-021 req_ready is 0 in ACCESS and RESP; requests presented in those states remain pending. Requesters hold valid until ready.
REQ-022 Arbitration when both ports are valid is round-robin: grant the port that is not last_grant. last_grant updates on every grant.
REQ-023 mem_a and mem_wd are driven from the latched request in ACCESS and RESP, and are 0 in IDLE.
REQ-024 In ACCESS, for an aligned store, exactly one strobe is asserted for exactly one cycle, selected by size. All strobes are 0 in every other state and cycle.
REQ-025 Alignment rules:
- half requires addr[0] = 0;
- word requires addr[1:0] = 00;
- byte is always aligned;
- size 11 is an error.
Errored requests assert no strobe and leave RAM unmodified.
REQ-026 In ACCESS, for an aligned load, mem_rd is captured into the response register:
- byte: mem_rd[7:0], sign- or zero-extended;
- half: mem_rd[15:0], sign- or zero-extended;
- word: mem_rd as-is.
REQ-027 In RESP:
- rsp_valid is asserted for the latched port for one cycle, with rsp_err and rsp_rdata.
- rsp_rdata is 0 for stores and for errors.
REQ-028 Latency: request accepted at edge N; the strobe/capture cycle lies between edges N and N+1; rsp_valid is high between edges N+1 and N+2. Throughput is one transaction per 3 cycles.
REQ-029 A request that becomes valid in RESP is not granted before the following IDLE cycle; there is no IDLE bypass.

Reset
REQ-030 While rst = 1:
- state = IDLE, last_grant = 1 (port 0 wins the first tie);
- all latched request fields and rsp_rdata are 0;
- req_ready, rsp_valid, rsp_err, mem_sb/sh/sw, mem_a and mem_wd are all 0.
REQ-031 Reset asserted mid-transaction takes effect immediately:
- the strobes drop without waiting for a clock edge;
- the pending transaction is discarded with no response;
- a store in ACCESS before the next edge is not performed.

Configuration
REQ-032 Macro DATA_MEM_ARBITER_RR_EN selects the arbitration policy.
- Defined: round-robin per REQ-022.
- Undefined: fixed priority, port 0 always wins ties, and last_grant is neither updated nor used.

Verification
REQ-033 Port 0 store word 0xDEADBEEF to 0x1004, then load word from 0x1004 -> mem_sw high exactly 1 cycle; second response rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 RAM 0x1010 = 0x80, port 1 load byte 0x1010 signed, then unsigned -> rsp_rdata = 0xFFFFFF80, then 0x00000080.
REQ-035 Both ports valid continuously, with and without DATA_MEM_ARBITER_RR_EN -> grants 0,1,0,1 with the macro; 0,0,0,0 without it (port 1 starved).
REQ-036 Port 0 store half to 0x1001, then word to 0x1002 -> no strobe ever asserted; rsp_err = 1 for both; RAM unchanged.
REQ-037 Port 0 store byte to 0x1000, rst pulsed mid-ACCESS before the edge -> mem_sb drops immediately, RAM byte unchanged, no rsp_valid, state IDLE.
REQ-038 Port 1 requests during RESP of a port 0 transaction -> req_ready[1] asserted only in the next IDLE cycle; rsp_valid never overlaps between ports.
